// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_debouncer: N-channel push-button sync + tick-based stability filter |
// | with one-clk press/release pulses. Optional auto-repeat: BTN_REPEAT_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module button_debouncer #(
  parameter int N_BTN        = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1_000,
  parameter int STABLE_TICKS = 10,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] pb,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rel
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] C_DIV_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [PW-1:0]          div_q, div_d;
  logic                   tick;
  logic [N_BTN-1:0]       s1_q, s2_q;
  logic [N_BTN-1:0]       level_q, level_d;
  logic [N_BTN-1:0]       press_q, press_d;
  logic [N_BTN-1:0]       rel_q, rel_d;
  logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;

`ifdef BTN_REPEAT_EN
  localparam int RW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [RW-1:0] C_RPT_LAST   = RW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] C_RPT_RELOAD = RW'(HOLD_TICKS - REPEAT_TICKS);

  logic [N_BTN-1:0][RW-1:0] rpt_q, rpt_d;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) rpt_q <= '0;
    else          rpt_q <= rpt_d;
  end
`else
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = ^{HOLD_TICKS, REPEAT_TICKS};
`endif

  assign tick = (div_q == C_DIV_LAST);

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    cnt_d   = cnt_q;
`ifdef BTN_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (s2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] < C_CNT_LAST) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i]   = '0;
          level_d[i] = s2_q[i];
          press_d[i] = s2_q[i];
          rel_d[i]   = ~s2_q[i];
        end
`ifdef BTN_REPEAT_EN
        // Reloading below HOLD_TICKS makes every later repeat REPEAT_TICKS apart.
        if (level_d[i] != level_q[i]) begin
          rpt_d[i] = '0;
        end else if (level_q[i]) begin
          if (rpt_q[i] == C_RPT_LAST) begin
            press_d[i] = 1'b1;
            rpt_d[i]   = C_RPT_RELOAD;
          end else begin
            rpt_d[i] = rpt_q[i] + 1'b1;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      s1_q    <= pb;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign btn_rel   = rel_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for button_debouncer (DIV=10, STABLE_TICKS=4, N_BTN=4).
module tb_button_debouncer;
  localparam int N = 4;

  logic         clk_in = 1'b0;
  logic         reset_n;
  logic [N-1:0] pb;
  logic [N-1:0] btn_level, btn_press, btn_rel;

  int           n_checks = 0;
  int           n_errors = 0;
  int           press_cnt [N];
  int           rel_cnt   [N];
  logic [N-1:0] watch_mask;
  logic [N-1:0] first_vec;
  logic [N-1:0] both_seen;

  always #5 clk_in = ~clk_in;

  button_debouncer #(
    .N_BTN(4), .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(4),
    .HOLD_TICKS(8), .REPEAT_TICKS(3)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .pb(pb),
    .btn_level(btn_level), .btn_press(btn_press), .btn_rel(btn_rel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    first_vec = '0;
  endtask

  // Advance n clocks, sampling outputs 1 time unit after each rising edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      for (int i = 0; i < N; i++) begin
        if (btn_press[i]) press_cnt[i]++;
        if (btn_rel[i])   rel_cnt[i]++;
      end
      both_seen = both_seen | (btn_press & btn_rel);
      if (first_vec == '0) first_vec = btn_press & watch_mask;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    pb         = 4'hF;
    watch_mask = 4'b1001;
    both_seen  = '0;
    clear_counts();
    run(3);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_rel",   btn_rel,   0);

    // Held buttons are accepted on tick 4 = clk 40 after release.
    reset_n = 1'b1;
    clear_counts();
    run(39);
    chk("pre_tick4_level", btn_level, 0);
    chk("pre_tick4_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    run(1);
    chk("tick4_level", btn_level, 4'hF);
    chk("tick4_press", btn_press, 4'hF);
    run(1);
    chk("tick4_press_width", btn_press, 0);
    for (int i = 0; i < N; i++) chk($sformatf("tick4_press_cnt%0d", i), press_cnt[i], 1);

    pb = 4'h0;
    clear_counts();
    run(42);
    chk("rel_all_level", btn_level, 0);
    for (int i = 0; i < N; i++) chk($sformatf("rel_all_cnt%0d", i), rel_cnt[i], 1);
    chk("rel_all_nopress", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Clean press on channel 0.
    pb[0] = 1'b1;
    clear_counts();
    run(42);
    chk("clean_press_cnt0", press_cnt[0], 1);
    for (int i = 1; i < N; i++) chk($sformatf("clean_other_press%0d", i), press_cnt[i], 0);
    chk("clean_level", btn_level, 4'b0001);

    // Bounce on channel 1: 15-clk segments never span 4 ticks.
    clear_counts();
    for (int k = 0; k < 14; k++) begin
      pb[1] = ~pb[1];
      run(15);
    end
    chk("bounce_no_press", press_cnt[1], 0);
    chk("bounce_no_rel",   rel_cnt[1],   0);
    chk("bounce_level",    btn_level[1], 0);
    pb[1] = 1'b1;
    clear_counts();
    run(42);
    chk("bounce_final_press", press_cnt[1], 1);
    chk("bounce_final_level", btn_level[1], 1);

    // 25-clk low glitch on channel 2 while held.
    pb[2] = 1'b1;
    run(42);
    chk("glitch_pre_level", btn_level[2], 1);
    clear_counts();
    pb[2] = 1'b0;
    run(25);
    pb[2] = 1'b1;
    run(45);
    chk("glitch_no_rel", rel_cnt[2],   0);
    chk("glitch_level",  btn_level[2], 1);
    pb[2] = 1'b0;
    clear_counts();
    run(42);
    chk("release2_cnt",   rel_cnt[2],   1);
    chk("release2_level", btn_level[2], 0);

    // Simultaneous rise on channels 0 and 3.
    pb[0] = 1'b0;
    run(42);
    chk("simul_pre_level0", btn_level[0], 0);
    clear_counts();
    pb[0] = 1'b1;
    pb[3] = 1'b1;
    run(42);
    chk("simul_press0", press_cnt[0], 1);
    chk("simul_press3", press_cnt[3], 1);
    chk("simul_same_clk", first_vec, 4'b1001);
    chk("simul_level", btn_level, 4'b1011);

    // Asynchronous reset while channels 0 and 3 are mid-filter.
    pb[0] = 1'b0;
    pb[3] = 1'b0;
    run(25);
    reset_n = 1'b0;
    #1;
    chk("async_rst_level", btn_level, 0);
    chk("async_rst_press", btn_press, 0);
    chk("async_rst_rel",   btn_rel,   0);
    pb = 4'b0010;
    run(2);
    reset_n = 1'b1;
    clear_counts();
    run(39);
    chk("rerst_pre_level", btn_level, 0);
    run(1);
    chk("rerst_level", btn_level, 4'b0010);
    chk("rerst_press", btn_press, 4'b0010);

`ifdef BTN_REPEAT_EN
    // Pulses at acceptance (clk 40), then clk 120, 150, 180.
    reset_n = 1'b0;
    pb      = 4'h0;
    run(2);
    reset_n = 1'b1;
    pb      = 4'b0001;
    clear_counts();
    run(40);
    chk("rpt_accept", press_cnt[0], 1);
    run(80);
    chk("rpt_first_repeat", press_cnt[0], 2);
    run(30);
    chk("rpt_second_repeat", press_cnt[0], 3);
    run(30);
    chk("rpt_third_repeat", press_cnt[0], 4);
    // The level stays 1 until the release is accepted, so one more repeat lands at clk 210.
    pb = 4'h0;
    clear_counts();
    run(42);
    chk("rpt_release_rel",   rel_cnt[0],   1);
    chk("rpt_release_press", press_cnt[0], 1);
    chk("rpt_release_level", btn_level[0], 0);
    clear_counts();
    run(60);
    chk("rpt_stopped", press_cnt[0], 0);
`endif

    chk("never_press_and_rel", both_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
